byte_align_ctrl: RTL

- Streaming realigner that turns a misaligned 128-bit source stream into byte-0-aligned 128-bit output beats.
- Sits between a memory-read return path and consumers that need aligned data, such as the DMA write side and vector load units.
- Sequences a 16-byte byte rotator, holds the previous source beat, merges it with the current beat, and generates the last-beat byte mask.

---
 rtl/byte_align_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/byte_align_ctrl.sv
// rtl/byte_align_ctrl.sv - 128-bit streaming byte realigner with last-beat mask
module byte_align_ctrl #(
    parameter int LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_offset,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [15:0]      out_mask,
    output logic             out_last,
    output logic             busy
);

    // Source beat count can reach 2^(LEN_W-4)+1, hence LEN_W-3 bits.
    localparam int CNT_W = LEN_W - 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [3:0]       off;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [15:0]      last_mask;
    logic [127:0]     hold;

    logic [LEN_W:0]   span;
    logic [CNT_W-1:0] n_in_calc;
    logic [CNT_W-1:0] n_out_calc;
    logic [15:0]      mask_calc;

    logic out_free;
    logic cmd_accept;
    logic prime_take;
    logic stream_take;
    logic flush_load;
    logic final_beat;

    function automatic logic [127:0] merge(input logic [127:0] h,
                                           input logic [127:0] c,
                                           input logic [3:0]   o);
        // Concatenate current over held beat and slide down by the offset.
        return 128'({c, h} >> {o, 3'b000});
    endfunction

    assign span       = {1'b0, cmd_len} + {{(LEN_W-3){1'b0}}, cmd_offset};
    assign n_in_calc  = span[LEN_W:4] + {{(CNT_W-1){1'b0}}, |span[3:0]};
    assign n_out_calc = {1'b0, cmd_len[LEN_W-1:4]} + {{(CNT_W-1){1'b0}}, |cmd_len[3:0]};
    assign mask_calc  = (cmd_len[3:0] == 4'd0) ? 16'hFFFF
                                               : ((16'h1 << cmd_len[3:0]) - 16'h1);

    assign out_free   = !out_valid || out_ready;
    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE) || out_valid;
    assign final_beat = flush_load || (out_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        cmd_accept  = 1'b0;
        prime_take  = 1'b0;
        stream_take = 1'b0;
        flush_load  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_accept = 1'b1;
                    if (cmd_len != '0) begin
                        state_nxt = PRIME;
                    end
                end
            end
            PRIME: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    prime_take = 1'b1;
                    state_nxt  = (in_cnt == CNT_W'(1)) ? FLUSH : STREAM;
                end
            end
            STREAM: begin
                in_ready = out_free;
                if (in_valid && out_free) begin
                    stream_take = 1'b1;
                    if (in_cnt == CNT_W'(1)) begin
                        // N_IN == N_OUT leaves one output beat to build from the tail of H.
                        state_nxt = (out_cnt != CNT_W'(1)) ? FLUSH : IDLE;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    flush_load = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off       <= 4'd0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            last_mask <= 16'h0000;
            hold      <= 128'd0;
            out_valid <= 1'b0;
            out_data  <= 128'd0;
            out_mask  <= 16'h0000;
            out_last  <= 1'b0;
        end else begin
            if (cmd_accept) begin
                off       <= cmd_offset;
                in_cnt    <= n_in_calc;
                out_cnt   <= n_out_calc;
                last_mask <= mask_calc;
            end

            if (prime_take) begin
                hold   <= in_data;
                in_cnt <= in_cnt - CNT_W'(1);
            end

            if (stream_take) begin
                hold    <= in_data;
                in_cnt  <= in_cnt - CNT_W'(1);
                out_cnt <= out_cnt - CNT_W'(1);
            end

            if (flush_load) begin
                out_cnt <= out_cnt - CNT_W'(1);
            end

            if (stream_take || flush_load) begin
                out_valid <= 1'b1;
                out_data  <= merge(hold, stream_take ? in_data : 128'd0, off);
                out_mask  <= final_beat ? last_mask : 16'hFFFF;
                out_last  <= final_beat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
